calc_datapath: RTL and testbench
================================

// Module: calc_datapath
// PURPOSE
//  Operand/result datapath downstream of the calculator control FSM. Consumes op_code,
//  wrt_addr and compute_op; loads operands from slide switches into reg_A and reg_B;
//  runs add, sub, mul or iterative div; drives a registered value to the 7-seg display.
//  Add/sub/mul complete in 1 edge. Div is multi-cycle, restoring, with busy/done.
// PARAMETERS
//  WIDTH  4  operand width in bits; result width is 2*WIDTH
// PORTS
//  clk         in   1        system clock, single clock domain
//  reset_n     in   1        asynchronous, active-low reset
//  op_code     in   3        000 NOOP,001 LOAD,010 DISP_A,100 DISP_B,101 COMPUTE,110 DISP_RES,111 CLEAR
//  wrt_addr    in   1        LOAD target: 0 = reg_A, 1 = reg_B
//  compute_op  in   2        00 add, 01 sub, 10 mul, 11 div (driven from top level)
//  sw_in       in   WIDTH    operand switches
//  reg_a       out  WIDTH    operand A
//  reg_b       out  WIDTH    operand B
//  result      out  2*WIDTH  last completed result
//  disp_val    out  2*WIDTH  registered display value
//  busy        out  1        division in progress
//  done        out  1        1-cycle pulse when result is written
//  neg         out  1        last sub result was negative
//  div_err     out  1        last div had B == 0
// BEHAVIOUR
//  - Reset (reset_n=0, async): all outputs 0, prev_op 000, divider idle. Applies mid-division too.
//  - prev_op: registers op_code every edge. op_edge = (op_code != prev_op).
//  - LOAD 001: reg[wrt_addr] <= sw_in on every edge while it is held.
//  - DISP_A 010 with op_edge: reg_a <= sw_in once. Later cycles in 010 do not reload.
//  - DISP_B 100 with op_edge: reg_b <= sw_in once. Same rule.
//  - disp_val, updated each edge by op_code:
//      001 -> zext(sw_in); 010 -> zext(sw_in if op_edge, else reg_a);
//      100 -> same rule with reg_b; 110 -> result; all other codes hold.
//  - COMPUTE 101 with op_edge and !busy: launch using compute_op, reg_a and reg_b.
//    COMPUTE with busy is ignored.
//    * add: result <= zext(A) + zext(B). Carry lands in bit WIDTH.
//    * sub: result <= A - B in 2*WIDTH two's complement; neg <= (A < B).
//    * mul: result <= A * B, unsigned.
//    * add/sub/mul: result written at the launch edge; done=1 for the following cycle.
//    * div, B != 0: at launch, latch A/B into internal regs and set busy.
//      Then WIDTH restoring iterations, one per edge.
//      At the last edge: result <= {remainder, quotient}; busy <= 0; done pulses the next cycle.
//      Total latency is WIDTH+1 edges from launch.
//    * div, B == 0: no iteration. result <= {A, all-ones}; div_err <= 1. Latency as for add.
//    * Each launch clears neg and div_err, except the flag that op itself sets.
//  - op_code leaving 101 mid-division: division still completes.
//    LOAD/DISP during busy change reg_a/reg_b only; the latched operands are unaffected.
//  - CLEAR 111 (synchronous): reg_a, reg_b, result, disp_val, neg, div_err, busy, done <= 0.
//    Aborts any division. Takes priority over all other actions.
//  - NOOP 000: no register change except prev_op. done self-clears.
//  - done is never high for 2 consecutive cycles.
// TESTING
//  1 reset_n=0 mid-run -> all outputs 0 immediately; busy=0 after release.
//  2 DISP_A edge with sw_in=9, then DISP_B edge with sw_in=3
//    -> reg_a=9, reg_b=3, disp_val=0x09 then 0x03.
//    Changing sw_in while DISP_A is held does not alter reg_a.
//  3 A=9,B=3 COMPUTE add -> result 0x0C, done 1 cycle.
//    Sub with A=3,B=9 -> result 0xFA, neg=1.
//  4 A=15,B=15 mul -> result 0xE1, done next cycle, busy never set.
//  5 A=13,B=4 div -> busy 4 cycles, result 0x13 (rem 1, quo 3), done 1 cycle.
//    CLEAR at iteration 2 -> busy=0, result=0, no done.
//  6 A=13,B=0 div -> result 0xDF, div_err=1, busy never set.
//    Next COMPUTE edge while busy is ignored; back-to-back COMPUTE without an op change does not relaunch.

Source files
------------

// File: rtl/calc_datapath.sv
// calc_datapath: operand/result datapath for the calculator (loads, add/sub/mul, restoring divide, display register)
// Ports:
//   clk, reset_n       single clock, asynchronous active-low reset
//   op_code[2:0]       000 NOOP, 001 LOAD, 010 DISP_A, 100 DISP_B, 101 COMPUTE, 110 DISP_RES, 111 CLEAR
//   wrt_addr           LOAD target (0 = reg_a, 1 = reg_b)
//   compute_op[1:0]    00 add, 01 sub, 10 mul, 11 div
//   sw_in[WIDTH-1:0]   operand switches
//   reg_a, reg_b       operand registers
//   result             last completed result (2*WIDTH)
//   disp_val           registered display value (2*WIDTH)
//   busy, done         division in progress / one-cycle completion pulse
//   neg, div_err       last sub was negative / last div had a zero divisor
module calc_datapath #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         op_code,
  input  logic               wrt_addr,
  input  logic [1:0]         compute_op,
  input  logic [WIDTH-1:0]   sw_in,
  output logic [WIDTH-1:0]   reg_a,
  output logic [WIDTH-1:0]   reg_b,
  output logic [2*WIDTH-1:0] result,
  output logic [2*WIDTH-1:0] disp_val,
  output logic               busy,
  output logic               done,
  output logic               neg,
  output logic               div_err
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_LOAD = 3'b001, OP_DISP_A = 3'b010, OP_DISP_B = 3'b100,
                         OP_COMPUTE = 3'b101, OP_DISP_RES = 3'b110, OP_CLEAR = 3'b111;
  localparam logic [1:0] C_ADD = 2'b00, C_SUB = 2'b01, C_MUL = 2'b10, C_DIV = 2'b11;

  logic [2:0]       prev_op;
  logic [WIDTH-1:0] dv_q, dv_b, dv_r;
  logic [CW-1:0]    cnt;
  logic             op_edge, launch, ge;
  logic [RW-1:0]    za, zb, zsw, alu, disp_nxt;
  logic [WIDTH:0]   sh, trial;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  // A launch is also held off while done is high so that a division finishing
  // right before a fresh COMPUTE edge cannot produce two back-to-back done pulses.
  always_comb begin
    op_edge = op_code != prev_op;
    launch  = op_code == OP_COMPUTE && op_edge && !busy && !done;
    za      = RW'(reg_a);
    zb      = RW'(reg_b);
    zsw     = RW'(sw_in);
    alu     = compute_op == C_ADD ? za + zb :
              compute_op == C_SUB ? za - zb :
              compute_op == C_MUL ? za * zb : {reg_a, {WIDTH{1'b1}}};
    disp_nxt = op_code == OP_LOAD    ? zsw :
               op_code == OP_DISP_A  ? (op_edge ? zsw : za) :
               op_code == OP_DISP_B  ? (op_edge ? zsw : zb) :
               op_code == OP_DISP_RES ? result : disp_val;
    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor if it fits.
    sh      = {dv_r, dv_q[WIDTH-1]};
    trial   = sh - {1'b0, dv_b};
    ge      = !trial[WIDTH];
    rem_nxt = ge ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
    quo_nxt = {dv_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_op  <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      result   <= '0;
      disp_val <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      neg      <= 1'b0;
      div_err  <= 1'b0;
      dv_q     <= '0;
      dv_b     <= '0;
      dv_r     <= '0;
      cnt      <= '0;
    end else begin
      prev_op <= op_code;
      done    <= 1'b0;
      if (op_code == OP_CLEAR) begin
        reg_a    <= '0;
        reg_b    <= '0;
        result   <= '0;
        disp_val <= '0;
        busy     <= 1'b0;
        neg      <= 1'b0;
        div_err  <= 1'b0;
      end else begin
        if (op_code == OP_LOAD && !wrt_addr) reg_a <= sw_in;
        if (op_code == OP_LOAD && wrt_addr) reg_b <= sw_in;
        if (op_code == OP_DISP_A && op_edge) reg_a <= sw_in;
        if (op_code == OP_DISP_B && op_edge) reg_b <= sw_in;
        disp_val <= disp_nxt;
        if (launch) begin
          neg     <= compute_op == C_SUB && reg_a < reg_b;
          div_err <= compute_op == C_DIV && reg_b == '0;
          if (compute_op == C_DIV && reg_b != '0) begin
            busy <= 1'b1;
            dv_q <= reg_a;
            dv_b <= reg_b;
            dv_r <= '0;
            cnt  <= CW'(WIDTH - 1);
          end else begin
            result <= alu;
            done   <= 1'b1;
          end
        end else if (busy) begin
          dv_r <= rem_nxt;
          dv_q <= quo_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            busy   <= 1'b0;
            result <= {rem_nxt, quo_nxt};
            done   <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_calc_datapath.sv
// tb_calc_datapath: directed scoreboard bench for calc_datapath
module tb_calc_datapath;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] op_code;
  logic       wrt_addr;
  logic [1:0] compute_op;
  logic [3:0] sw_in;
  logic [3:0] reg_a, reg_b;
  logic [7:0] result, disp_val;
  logic       busy, done, neg, div_err;

  typedef struct {
    logic [7:0] res;
    logic       neg;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_done = 1'b0;

  calc_datapath #(.WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .op_code(op_code), .wrt_addr(wrt_addr),
    .compute_op(compute_op), .sw_in(sw_in), .reg_a(reg_a), .reg_b(reg_b),
    .result(result), .disp_val(disp_val), .busy(busy), .done(done),
    .neg(neg), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; one rising edge passes before return.
  task automatic drive(input logic [2:0] op, input logic [3:0] sw, input logic wa, input logic [1:0] cop);
    op_code    = op;
    sw_in      = sw;
    wrt_addr   = wa;
    compute_op = cop;
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b);
    drive(3'b001, a, 1'b0, 2'b00);
    drive(3'b001, b, 1'b1, 2'b00);
  endtask

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done && prev_done) chk("done_twice", 1, 0);
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_result", 32'(result), 32'(e.res));
          chk("sb_neg", 32'(neg), 32'(e.neg));
          chk("sb_div_err", 32'(div_err), 32'(e.err));
        end
      end
    end
    prev_done <= done;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    reset_n = 1'b0;
    op_code = 3'b000; wrt_addr = 1'b0; compute_op = 2'b00; sw_in = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({reg_a, reg_b, result, disp_val, busy, done, neg, div_err}), 0);
    reset_n = 1'b1;
    drive(3'b000, 4'h0, 1'b0, 2'b00);

    drive(3'b010, 4'h9, 1'b0, 2'b00);
    chk("disp_a_reg", 32'(reg_a), 9);
    chk("disp_a_val", 32'(disp_val), 8'h09);
    drive(3'b010, 4'h5, 1'b0, 2'b00);
    chk("disp_a_hold_reg", 32'(reg_a), 9);
    chk("disp_a_hold_val", 32'(disp_val), 8'h09);
    drive(3'b100, 4'h3, 1'b0, 2'b00);
    chk("disp_b_reg", 32'(reg_b), 3);
    chk("disp_b_val", 32'(disp_val), 8'h03);

    exp_q.push_back('{8'h0C, 1'b0, 1'b0});
    drive(3'b101, 4'h0, 1'b0, 2'b00);
    chk("add_busy", 32'(busy), 0);
    drive(3'b101, 4'h0, 1'b0, 2'b00);
    drive(3'b101, 4'h0, 1'b0, 2'b00);
    drive(3'b000, 4'h0, 1'b0, 2'b00);

    load(4'h3, 4'h9);
    chk("load_a", 32'(reg_a), 3);
    chk("load_b_disp", 32'(disp_val), 8'h09);
    exp_q.push_back('{8'hFA, 1'b1, 1'b0});
    drive(3'b101, 4'h0, 1'b0, 2'b01);
    drive(3'b110, 4'h0, 1'b0, 2'b00);
    chk("disp_res", 32'(disp_val), 8'hFA);

    load(4'hF, 4'hF);
    exp_q.push_back('{8'hE1, 1'b0, 1'b0});
    drive(3'b101, 4'h0, 1'b0, 2'b10);
    chk("mul_busy", 32'(busy), 0);
    drive(3'b000, 4'h0, 1'b0, 2'b00);

    load(4'hD, 4'h4);
    exp_q.push_back('{8'h13, 1'b0, 1'b0});
    drive(3'b101, 4'h0, 1'b0, 2'b11);
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      if (cyc == 1) drive(3'b001, 4'h7, 1'b0, 2'b00);
      else if (cyc == 2) drive(3'b101, 4'h0, 1'b0, 2'b11);
      else drive(3'b000, 4'h0, 1'b0, 2'b00);
    end
    chk("div_busy_cycles", cyc, 4);
    chk("div_reg_a_reloaded", 32'(reg_a), 7);
    repeat (3) drive(3'b000, 4'h0, 1'b0, 2'b00);
    chk("div_result_held", 32'(result), 8'h13);

    load(4'hD, 4'h4);
    drive(3'b101, 4'h0, 1'b0, 2'b11);
    drive(3'b000, 4'h0, 1'b0, 2'b00);
    drive(3'b111, 4'h0, 1'b0, 2'b00);
    chk("clear_busy", 32'(busy), 0);
    chk("clear_result", 32'(result), 0);
    chk("clear_regs", 32'({reg_a, reg_b, disp_val}), 0);
    repeat (6) drive(3'b000, 4'h0, 1'b0, 2'b00);
    chk("clear_no_result", 32'(result), 0);

    load(4'hD, 4'h0);
    exp_q.push_back('{8'hDF, 1'b0, 1'b1});
    drive(3'b101, 4'h0, 1'b0, 2'b11);
    chk("divz_busy", 32'(busy), 0);
    drive(3'b000, 4'h0, 1'b0, 2'b00);

    load(4'hD, 4'h4);
    drive(3'b101, 4'h0, 1'b0, 2'b11);
    drive(3'b000, 4'h0, 1'b0, 2'b00);
    chk("mid_div_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({reg_a, reg_b, result, disp_val, busy, done, neg, div_err}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) drive(3'b000, 4'h0, 1'b0, 2'b00);
    chk("post_reset_busy", 32'(busy), 0);
    chk("post_reset_result", 32'(result), 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
